// File: rtl/checked_adder_sched_pkg.sv
// Shared types and constants for the checked adder scheduler.
package checked_adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int NREQ      = 2;
  localparam int ERR_CNT_W = 16;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/checked_adder_sched_adder.sv
// Duplicated carry-select adder: rail A adds a+b, rail B adds ~a+~b+1 = ~(a+b).
// Parity of the rail-A sum is predicted using rail B's carry chain.
module duplicated_carry_select_adder_parameter #(
  parameter int WIDTH = 64,
  parameter int BLK   = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             pa_i,
  input  logic             pb_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] s_invert_o,
  output logic             papb_o,
  output logic             pab_o
);

  localparam logic ODD_W = ((WIDTH % 2) == 1) ? 1'b1 : 1'b0;

  // Returns either the sum or the per-bit carry-in vector of a block carry-select add.
  function automatic logic [WIDTH-1:0] cs_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             cin,
                                               input logic             want_carry);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] cvec;
    logic c_blk, c0, c1, p;
    sum   = {WIDTH{1'b0}};
    cvec  = {WIDTH{1'b0}};
    c_blk = cin;
    c0    = 1'b0;
    c1    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i % BLK) == 0) && (i != 0)) begin
        c_blk = c_blk ? c1 : c0;
        c0    = 1'b0;
        c1    = 1'b1;
      end
      p       = a[i] ^ b[i];
      sum[i]  = c_blk ? (p ^ c1) : (p ^ c0);
      cvec[i] = c_blk ? c1 : c0;
      c0      = (a[i] & b[i]) | (c0 & p);
      c1      = (a[i] & b[i]) | (c1 & p);
    end
    return want_carry ? cvec : sum;
  endfunction

  logic [WIDTH-1:0] sum_a_s;
  logic [WIDTH-1:0] sum_b_s;
  logic [WIDTH-1:0] carry_b_s;

  assign sum_a_s   = cs_add(a_i, b_i, 1'b0, 1'b0);
  assign sum_b_s   = cs_add(~a_i, ~b_i, 1'b1, 1'b0);
  assign carry_b_s = cs_add(~a_i, ~b_i, 1'b1, 1'b1);

  // Rail B carries are the complement of rail A carries, hence the width-parity fixup.
  assign s_o        = sum_a_s;
  assign s_invert_o = sum_b_s;
  assign papb_o     = pa_i ^ pb_i;
  assign pab_o      = (^sum_a_s) ^ (^carry_b_s) ^ ODD_W;

endmodule

// File: rtl/checked_adder_sched.sv
// Round-robin scheduler in front of the self-checking adder, with retry on
// detected errors and a sticky fault flag once retries run out.
module checked_adder_sched
  import checked_adder_sched_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_RETRY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic                 rsp_id,
  output logic                 rsp_err,
  output logic                 fault_o,
  input  logic                 fault_clr,
  input  logic                 err_inj,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic                 pa_q, pa_d, pb_q, pb_d;
  logic                 id_q, id_d;
  logic [2:0]           retry_q, retry_d;
  logic [WIDTH-1:0]     s_q, s_d, si_q, si_d;
  logic                 papb_q, papb_d, pab_q, pab_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 fault_q, fault_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 grant_s, hs_s, err_s, fault_set_s;
  logic [WIDTH-1:0]     add_s, add_si;
  logic                 add_papb, add_pab;

  duplicated_carry_select_adder_parameter #(.WIDTH(WIDTH)) u_adder (
    .a_i        (op_a_q),
    .b_i        (op_b_q),
    .pa_i       (pa_q),
    .pb_i       (pb_q),
    .s_o        (add_s),
    .s_invert_o (add_si),
    .papb_o     (add_papb),
    .pab_o      (add_pab)
  );

  // Arbitration: alternate on contention, otherwise serve whoever is valid.
  always_comb begin
    grant_s   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    req_ready = ((state_q == IDLE) && req_valid[grant_s]) ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
    hs_s      = |req_ready;
    err_s     = (s_q != ~si_q) | (papb_q != pab_q);
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    pa_d        = pa_q;
    pb_d        = pb_q;
    id_d        = id_q;
    retry_d     = retry_q;
    s_d         = s_q;
    si_d        = si_q;
    papb_d      = papb_q;
    pab_d       = pab_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    fault_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          op_a_d  = grant_s ? req_a1 : req_a0;
          op_b_d  = grant_s ? req_b1 : req_b0;
          pa_d    = grant_s ? ^req_a1 : ^req_a0;
          pb_d    = grant_s ? ^req_b1 : ^req_b0;
          id_d    = grant_s;
          retry_d = 3'd0;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        s_d     = add_s;
        si_d    = {add_si[WIDTH-1:1], add_si[0] ^ err_inj};
        papb_d  = add_papb;
        pab_d   = add_pab;
        state_d = CHECK;
      end
      CHECK: begin
        if (!err_s) begin
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (retry_q < MAX_RETRY_C) begin
          retry_d   = retry_q + 3'd1;
          err_cnt_d = sat_inc(err_cnt_q);
          state_d   = EXEC;
        end else begin
          err_cnt_d   = sat_inc(err_cnt_q);
          fault_set_s = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new fault outranks a simultaneous clear.
    fault_d = fault_set_s ? 1'b1 : (fault_clr ? 1'b0 : fault_q);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      op_a_q    <= {WIDTH{1'b0}};
      op_b_q    <= {WIDTH{1'b0}};
      pa_q      <= 1'b0;
      pb_q      <= 1'b0;
      id_q      <= 1'b0;
      retry_q   <= 3'd0;
      s_q       <= {WIDTH{1'b0}};
      si_q      <= {WIDTH{1'b1}};
      papb_q    <= 1'b0;
      pab_q     <= 1'b0;
      rsp_err_q <= 1'b0;
      fault_q   <= 1'b0;
      err_cnt_q <= {ERR_CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      id_q      <= id_d;
      retry_q   <= retry_d;
      s_q       <= s_d;
      si_q      <= si_d;
      papb_q    <= papb_d;
      pab_q     <= pab_d;
      rsp_err_q <= rsp_err_d;
      fault_q   <= fault_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = s_q;
  assign rsp_id    = id_q;
  assign rsp_err   = rsp_err_q;
  assign fault_o   = fault_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_checked_adder_sched.sv
// Directed bench for checked_adder_sched with a transaction-level reference model.
module tb_checked_adder_sched;

  localparam int W  = 64;
  localparam int MR = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [W-1:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_sum;
  logic          rsp_id;
  logic          rsp_err;
  logic          fault_o;
  logic          fault_clr = 1'b0;
  logic          err_inj = 1'b0;
  logic [15:0]   err_cnt;

  checked_adder_sched #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .fault_o   (fault_o),
    .fault_clr (fault_clr),
    .err_inj   (err_inj),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: one outstanding operation, attempts alternate
  // EXEC/CHECK after the accept, error on an attempt iff err_inj was high in its EXEC.
  logic        m_busy = 1'b0, m_resp = 1'b0, m_inj = 1'b0, m_id = 1'b0, m_err = 1'b0;
  logic        m_last = 1'b1, m_fault = 1'b0;
  logic [63:0] m_sum = '0;
  int          m_age = 0, m_try = 0, m_errcnt = 0;

  always @(negedge clk) begin
    logic       g, fset;
    logic [1:0] exp_rdy;
    if (rst) begin
      m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1;
      m_errcnt = 0; m_fault = 1'b0;
    end else begin
      g       = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      exp_rdy = (!m_busy && req_valid[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("m_req_ready", req_ready, exp_rdy);
      chk("m_rsp_valid", rsp_valid, m_resp);
      chk("m_err_cnt", err_cnt, m_errcnt);
      chk("m_fault", fault_o, m_fault);
      if (m_resp) begin
        chk("m_rsp_sum", rsp_sum, m_sum);
        chk("m_rsp_id", rsp_id, m_id);
        chk("m_rsp_err", rsp_err, m_err);
      end
      fset = 1'b0;
      if (m_resp) begin
        if (rsp_ready) begin
          m_busy = 1'b0; m_resp = 1'b0; m_last = m_id;
        end
      end else if (m_busy) begin
        m_age++;
        if ((m_age % 2) == 1) m_inj = err_inj;
        else if (!m_inj) begin
          m_err = 1'b0; m_resp = 1'b1;
        end else begin
          if (m_errcnt < 65535) m_errcnt++;
          if (m_try < MR) m_try++;
          else begin
            m_err = 1'b1; m_resp = 1'b1; fset = 1'b1;
          end
        end
      end else if (exp_rdy != 2'b00) begin
        m_busy = 1'b1; m_age = 0; m_try = 0; m_id = g; m_err = 1'b0;
        m_sum  = g ? req_a1 + req_b1 : req_a0 + req_b0;
      end
      m_fault = fset ? 1'b1 : (fault_clr ? 1'b0 : m_fault);
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0; err_inj = 1'b0; fault_clr = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] sums[4];
    logic        ids[4];
    int          n;

    do_reset();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_sum", rsp_sum, 64'h0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_fault", fault_o, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'h0);

    // Wrap-around add from requester 0.
    req_a0 = 64'h1; req_b0 = 64'hFFFF_FFFF_FFFF_FFFF; req_valid = 2'b01;
    #1 chk("t1_ready_c0", req_ready, 2'b01);
    step(); req_valid = 2'b00; chk("t1_valid_c1", rsp_valid, 1'b0);
    step(); chk("t1_valid_c2", rsp_valid, 1'b0);
    step();
    chk("t1_valid_c3", rsp_valid, 1'b1);
    chk("t1_sum", rsp_sum, 64'h0);
    chk("t1_id", rsp_id, 1'b0);
    chk("t1_err", rsp_err, 1'b0);
    chk("t1_err_cnt", err_cnt, 16'h0);
    rsp_ready = 1'b1;
    step(); rsp_ready = 1'b0; chk("t1_done", rsp_valid, 1'b0);

    // Round-robin with both requesters permanently valid.
    do_reset();
    req_a0 = 64'h10; req_b0 = 64'h20; req_a1 = 64'hFFFF_FFFF_FFFF_FFFF; req_b1 = 64'h2;
    req_valid = 2'b11; rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (rsp_valid) begin
        sums[n] = rsp_sum; ids[n] = rsp_id; n++;
        if (n == 4) req_valid = 2'b00;
      end
    end
    rsp_ready = 1'b0; req_valid = 2'b00;
    chk("t2_count", n, 4);
    if (n == 4) begin
      chk("t2_id0", ids[0], 1'b0);  chk("t2_sum0", sums[0], 64'h30);
      chk("t2_id1", ids[1], 1'b1);  chk("t2_sum1", sums[1], 64'h1);
      chk("t2_id2", ids[2], 1'b0);  chk("t2_sum2", sums[2], 64'h30);
      chk("t2_id3", ids[3], 1'b1);  chk("t2_sum3", sums[3], 64'h1);
    end
    step();

    // Single injected error, recovered by the retry.
    do_reset();
    req_a0 = 64'd5; req_b0 = 64'd7; req_valid = 2'b01;
    step(); req_valid = 2'b00; err_inj = 1'b1;
    step(); err_inj = 1'b0;
    step(); step(); chk("t3_valid_c4", rsp_valid, 1'b0);
    step();
    chk("t3_valid_c5", rsp_valid, 1'b1);
    chk("t3_sum", rsp_sum, 64'd12);
    chk("t3_err", rsp_err, 1'b0);
    chk("t3_err_cnt", err_cnt, 16'd1);
    chk("t3_fault", fault_o, 1'b0);
    rsp_ready = 1'b1;
    step(); rsp_ready = 1'b0;

    // Persistent error exhausts retries, then the sticky fault is cleared.
    do_reset();
    req_a0 = 64'd3; req_b0 = 64'd4; req_valid = 2'b01; err_inj = 1'b1;
    step(); req_valid = 2'b00;
    step(); step(); step(); step();
    chk("t4_valid_c5", rsp_valid, 1'b1);
    chk("t4_err", rsp_err, 1'b1);
    chk("t4_sum", rsp_sum, 64'd7);
    chk("t4_err_cnt", err_cnt, 16'd2);
    chk("t4_fault", fault_o, 1'b1);
    rsp_ready = 1'b1; err_inj = 1'b0;
    step(); rsp_ready = 1'b0;
    chk("t4_fault_held", fault_o, 1'b1);
    fault_clr = 1'b1;
    step(); fault_clr = 1'b0;
    chk("t4_fault_clr", fault_o, 1'b0);

    // Reset during CHECK drops the transaction and clears the error count.
    req_a0 = 64'd9; req_b0 = 64'd9; req_valid = 2'b01;
    step(); req_valid = 2'b00;
    step(); rst = 1'b1;
    step();
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_rsp_sum", rsp_sum, 64'h0);
    chk("t6_rsp_id", rsp_id, 1'b0);
    chk("t6_rsp_err", rsp_err, 1'b0);
    chk("t6_fault", fault_o, 1'b0);
    chk("t6_err_cnt", err_cnt, 16'h0);
    chk("t6_req_ready", req_ready, 2'b00);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t6_no_rsp", rsp_valid, 1'b0);
    end

    // Back-pressure in RESP with both requesters waiting.
    do_reset();
    req_a0 = 64'd100; req_b0 = 64'd200; req_a1 = 64'd40; req_b1 = 64'd2;
    req_valid = 2'b11; rsp_ready = 1'b0;
    step(); step(); step();
    for (int c = 0; c < 4; c++) begin
      chk("t5_valid", rsp_valid, 1'b1);
      chk("t5_sum", rsp_sum, 64'd300);
      chk("t5_id", rsp_id, 1'b0);
      chk("t5_ready_blocked", req_ready, 2'b00);
      if (c < 3) step();
    end
    rsp_ready = 1'b1;
    step(); rsp_ready = 1'b0;
    #1 chk("t5_next_grant", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    chk("t5_busy_again", req_ready, 2'b00);
    step(); step();
    chk("t5_valid2", rsp_valid, 1'b1);
    chk("t5_sum2", rsp_sum, 64'd42);
    chk("t5_id2", rsp_id, 1'b1);
    rsp_ready = 1'b1;
    step(); rsp_ready = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
